// File: rtl/ag32gbd_frame_scanner.sv
// Frame scanner: walks a WIDTHxHEIGHT frame, samples each pixel over a SampleStart/SampleDone
// handshake and writes Game Boy 2bpp tile bytes. Optional macro: AG32GBD_SCAN_TIMEOUT_EN.
module ag32gbd_frame_scanner #(
   parameter int WIDTH          = 128,
   parameter int HEIGHT         = 112,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        sys_clock,
   input  logic        sys_resetn,
   input  logic        FrameStart,
   output logic        FrameBusy,
   output logic        FrameDone,
   output logic        SampleStart,
   output logic [6:0]  PixelX,
   output logic [6:0]  PixelY,
   input  logic        SampleDone,
   input  logic [1:0]  SampledValue,
   output logic        BufWrEn,
   output logic [11:0] BufWrAddr,
   output logic [7:0]  BufWrData,
   output logic        TimeoutErr,
   output logic [2:0]  DbgState
);

   // Handshake: SampleStart is a level request held from S_START until the cycle a SampleDone
   // rising edge is seen; SampledValue is taken only on that edge. The next request waits for
   // SampleDone to drop and then GAP_CYCLES more cycles, so the sampler's edge detect re-arms.
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_WAIT_DONE = 3'd2,
      S_WAIT_LOW  = 3'd3,
      S_WRITE_LO  = 3'd4,
      S_WRITE_HI  = 3'd5,
      S_NEXT      = 3'd6
   } state_t;

   localparam logic [6:0] X_LAST   = 7'(WIDTH - 1);
   localparam logic [6:0] Y_LAST   = 7'(HEIGHT - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES);

   state_t      state_q, state_d;
   logic [6:0]  x_q, x_d, y_q, y_d;
   logic [7:0]  plane_lo_q, plane_lo_d, plane_hi_q, plane_hi_d;
   logic [7:0]  gap_q, gap_d;
   logic        busy_q, busy_d;
   logic        done_prev_q;
   logic        done_rise, last_px;

   assign done_rise = SampleDone & ~done_prev_q;
   assign last_px   = (x_q == X_LAST) && (y_q == Y_LAST);

`ifdef AG32GBD_SCAN_TIMEOUT_EN
   localparam logic [12:0] TO_LAST = 13'(TIMEOUT_CYCLES - 1);
   logic [12:0] to_q, to_d;
   logic        err_q, err_d;
   logic        expire;
   assign expire = (to_q == TO_LAST);
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^13'(TIMEOUT_CYCLES);
`endif

   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         state_q     <= S_IDLE;
         x_q         <= 7'd0;
         y_q         <= 7'd0;
         plane_lo_q  <= 8'd0;
         plane_hi_q  <= 8'd0;
         gap_q       <= 8'd0;
         busy_q      <= 1'b0;
         done_prev_q <= 1'b0;
`ifdef AG32GBD_SCAN_TIMEOUT_EN
         to_q        <= 13'd0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         plane_lo_q  <= plane_lo_d;
         plane_hi_q  <= plane_hi_d;
         gap_q       <= gap_d;
         busy_q      <= busy_d;
         done_prev_q <= SampleDone;
`ifdef AG32GBD_SCAN_TIMEOUT_EN
         to_q        <= to_d;
         err_q       <= err_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      plane_lo_d = plane_lo_q;
      plane_hi_d = plane_hi_q;
      gap_d      = gap_q;
      busy_d     = busy_q;
`ifdef AG32GBD_SCAN_TIMEOUT_EN
      to_d       = to_q;
      err_d      = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (FrameStart) begin
               x_d     = 7'd0;
               y_d     = 7'd0;
               busy_d  = 1'b1;
`ifdef AG32GBD_SCAN_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = S_START;
            end
         end
         S_START: begin
`ifdef AG32GBD_SCAN_TIMEOUT_EN
            to_d    = 13'd0;
`endif
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // A real edge wins over a coincident timeout expiry.
            if (done_rise) begin
               plane_lo_d = {plane_lo_q[6:0], SampledValue[0]};
               plane_hi_d = {plane_hi_q[6:0], SampledValue[1]};
               gap_d      = 8'd0;
               state_d    = S_WAIT_LOW;
            end
`ifdef AG32GBD_SCAN_TIMEOUT_EN
            else if (expire) begin
               plane_lo_d = {plane_lo_q[6:0], 1'b0};
               plane_hi_d = {plane_hi_q[6:0], 1'b0};
               err_d      = 1'b1;
               gap_d      = 8'd0;
               state_d    = S_WAIT_LOW;
            end else begin
               to_d = to_q + 13'd1;
            end
`endif
         end
         S_WAIT_LOW: begin
            if (SampleDone) begin
               gap_d = 8'd0;
            end else if (gap_q == GAP_LAST) begin
               state_d = (x_q[2:0] == 3'd7) ? S_WRITE_LO : S_NEXT;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         S_WRITE_LO: state_d = S_WRITE_HI;
         S_WRITE_HI: state_d = S_NEXT;
         S_NEXT: begin
            if (last_px) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               if (x_q == X_LAST) begin
                  x_d = 7'd0;
                  y_d = y_q + 7'd1;
               end else begin
                  x_d = x_q + 7'd1;
               end
               state_d = S_START;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      FrameBusy   = busy_q;
      FrameDone   = (state_q == S_NEXT) && last_px;
      SampleStart = (state_q == S_START) || (state_q == S_WAIT_DONE);
      PixelX      = x_q;
      PixelY      = y_q;
      BufWrEn     = 1'b0;
      BufWrAddr   = 12'd0;
      BufWrData   = 8'd0;
      DbgState    = state_q;
      // Tile index is {Y[6:3],X[6:3]}, 16 bytes per tile, low plane byte first.
      if ((state_q == S_WRITE_LO) || (state_q == S_WRITE_HI)) begin
         BufWrEn   = 1'b1;
         BufWrAddr = {y_q[6:3], x_q[6:3], y_q[2:0], (state_q == S_WRITE_HI)};
         BufWrData = (state_q == S_WRITE_HI) ? plane_hi_q : plane_lo_q;
      end
`ifdef AG32GBD_SCAN_TIMEOUT_EN
      TimeoutErr = err_q;
`else
      TimeoutErr = 1'b0;
`endif
   end

endmodule

// File: tb/tb_ag32gbd_frame_scanner.sv
// Bench for ag32gbd_frame_scanner: reduced 64x16 frame, randomized sampler timing and values,
// tile-byte scoreboard built from per-pixel values; timeout case when AG32GBD_SCAN_TIMEOUT_EN.
module tb_ag32gbd_frame_scanner;

   localparam int W      = 64;
   localparam int H      = 16;
   localparam int GAP    = 2;
   localparam int TO     = 4096;
   localparam int NWR    = 2 * W * H / 8;
   localparam int LAST_A = ((((H - 1) / 8) * 16 + (W - 1) / 8) * 16) + ((H - 1) % 8) * 2;
   localparam int BUDGET = 30000;

   logic        sys_clock, sys_resetn, FrameStart;
   logic        FrameBusy, FrameDone, SampleStart, SampleDone;
   logic [6:0]  PixelX, PixelY;
   logic [1:0]  SampledValue;
   logic        BufWrEn, TimeoutErr;
   logic [11:0] BufWrAddr;
   logic [7:0]  BufWrData;
   logic [2:0]  DbgState;

   ag32gbd_frame_scanner #(.WIDTH(W), .HEIGHT(H), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
      .sys_clock(sys_clock), .sys_resetn(sys_resetn), .FrameStart(FrameStart),
      .FrameBusy(FrameBusy), .FrameDone(FrameDone), .SampleStart(SampleStart),
      .PixelX(PixelX), .PixelY(PixelY), .SampleDone(SampleDone), .SampledValue(SampledValue),
      .BufWrEn(BufWrEn), .BufWrAddr(BufWrAddr), .BufWrData(BufWrData),
      .TimeoutErr(TimeoutErr), .DbgState(DbgState)
   );

   // clock / reset block
   int cyc = 0;
   initial begin
      sys_clock = 1'b0;
      forever #5 sys_clock = ~sys_clock;
   end
   always @(posedge sys_clock) cyc <= cyc + 1;

   int          errors = 0;
   int          checks = 0;
   logic [19:0] exp_q[$];
   logic [1:0]  pix_val [0:H-1][0:W-1];
   logic [7:0]  mem [0:4095];
   int          silent_x = -1, silent_y = -1;
   bit          mon_en = 0;
   int          wr_cnt = 0, done_cnt = 0, last_wr_cyc = 0;
   int          last_wr_addr = -1, prev_wr_addr = -1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference model: pixel values -> expected tile byte stream in write order
   task automatic fill_pattern();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) pix_val[y][x] = 2'((x + y) & 3);
   endtask

   task automatic fill_random();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) pix_val[y][x] = 2'($urandom_range(0, 3));
   endtask

   task automatic build_exp();
      exp_q.delete();
      for (int y = 0; y < H; y++) begin
         for (int tx = 0; tx < W / 8; tx++) begin
            logic [7:0] lo, hi;
            int a;
            for (int i = 0; i < 8; i++) begin
               lo[7 - i] = pix_val[y][tx * 8 + i][0];
               hi[7 - i] = pix_val[y][tx * 8 + i][1];
            end
            a = ((y / 8) * 16 + tx) * 16 + (y % 8) * 2;
            exp_q.push_back({12'(a), lo});
            exp_q.push_back({12'(a + 1), hi});
         end
      end
   endtask

   // sampler model: answers each SampleStart rise after 1..4 cycles, holds done 1..4 cycles
   initial begin
      bit ss_prev;
      SampleDone = 1'b0;
      SampledValue = 2'd0;
      ss_prev = 1'b0;
      forever begin
         @(negedge sys_clock);
         if (sys_resetn && SampleStart && !ss_prev &&
             !(int'(PixelX) == silent_x && int'(PixelY) == silent_y)) begin
            repeat ($urandom_range(1, 4)) @(negedge sys_clock);
            SampledValue = pix_val[PixelY][PixelX];
            SampleDone = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge sys_clock);
            SampleDone = 1'b0;
            SampledValue = 2'($urandom);
         end
         ss_prev = SampleStart;
      end
   end

   // monitor / scoreboard: writes, FrameDone count, gap rule, pixel stability
   initial begin
      logic [19:0] exp_item;
      bit          first_px, hold_prev, ss_mon_prev;
      int          low_cnt;
      logic [6:0]  px_prev, py_prev;
      first_px = 1'b1; hold_prev = 1'b0; ss_mon_prev = 1'b0; low_cnt = 0;
      px_prev = 7'd0; py_prev = 7'd0;
      forever begin
         @(negedge sys_clock);
         #1;
         if (!sys_resetn || !mon_en) begin
            first_px = 1'b1;
            hold_prev = 1'b0;
            low_cnt = 0;
         end else begin
            if (BufWrEn) begin
               exp_item = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
               check("wr_addr", 32'(BufWrAddr), 32'(exp_item[19:8]));
               check("wr_data", 32'(BufWrData), 32'(exp_item[7:0]));
               mem[BufWrAddr] = BufWrData;
               wr_cnt++;
               prev_wr_addr = last_wr_addr;
               last_wr_addr = int'(BufWrAddr);
               last_wr_cyc = cyc;
            end
            if (FrameDone) done_cnt++;
            if (SampleStart && !ss_mon_prev) begin
               if (!first_px) check("gap_min", (low_cnt < GAP) ? low_cnt : GAP, GAP);
               first_px = 1'b0;
            end
            if (SampleDone) low_cnt = 0;
            else if (!SampleStart) low_cnt++;
            if ((SampleStart || SampleDone) && hold_prev) begin
               check("pix_x_stable", 32'(PixelX), 32'(px_prev));
               check("pix_y_stable", 32'(PixelY), 32'(py_prev));
            end
            hold_prev = SampleStart || SampleDone;
            px_prev = PixelX;
            py_prev = PixelY;
         end
         ss_mon_prev = SampleStart;
      end
   end

   // driver tasks
   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(FrameBusy), 0);
      check({tag, "_done"}, 32'(FrameDone), 0);
      check({tag, "_sstart"}, 32'(SampleStart), 0);
      check({tag, "_px"}, 32'(PixelX), 0);
      check({tag, "_py"}, 32'(PixelY), 0);
      check({tag, "_wren"}, 32'(BufWrEn), 0);
      check({tag, "_waddr"}, 32'(BufWrAddr), 0);
      check({tag, "_wdata"}, 32'(BufWrData), 0);
      check({tag, "_toerr"}, 32'(TimeoutErr), 0);
      check({tag, "_state"}, 32'(DbgState), 0);
   endtask

   task automatic start_frame(input string tag);
      wr_cnt = 0;
      done_cnt = 0;
      FrameStart = 1'b1;
      @(negedge sys_clock);
      FrameStart = 1'b0;
      check({tag, "_busy_on"}, 32'(FrameBusy), 1);
      check({tag, "_x0"}, 32'(PixelX), 0);
      check({tag, "_y0"}, 32'(PixelY), 0);
      check({tag, "_sstart_on"}, 32'(SampleStart), 1);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (FrameDone !== 1'b1 && n < BUDGET) begin
         @(negedge sys_clock);
         n++;
      end
      check({tag, "_done_in_time"}, 32'(n < BUDGET), 1);
   endtask

   task automatic end_frame(input string tag);
      #2;
      check({tag, "_done_after_wr"}, cyc, last_wr_cyc + 1);
      check({tag, "_wr_count"}, wr_cnt, NWR);
      check({tag, "_exp_left"}, exp_q.size(), 0);
      check({tag, "_last_lo"}, prev_wr_addr, LAST_A);
      check({tag, "_last_hi"}, last_wr_addr, LAST_A + 1);
      @(negedge sys_clock);
      check({tag, "_busy_off"}, 32'(FrameBusy), 0);
      check({tag, "_done_pulse"}, 32'(FrameDone), 0);
      check({tag, "_done_cnt"}, done_cnt, 1);
   endtask

   task automatic abort_reset();
      mon_en = 1'b0;
      sys_resetn = 1'b0;
      #2;
      check_all_zero("abort");
      repeat (3) @(negedge sys_clock);
      sys_resetn = 1'b1;
      repeat (20) @(negedge sys_clock);
      exp_q.delete();
   endtask

   initial begin
      int n;
      int t0;
      sys_resetn = 1'b0;
      FrameStart = 1'b0;
      repeat (3) @(negedge sys_clock);
      check_all_zero("reset");
      sys_resetn = 1'b1;
      @(negedge sys_clock);

      // frame A: (x+y)&3 pattern, stray FrameStart mid-frame
      fill_pattern();
      build_exp();
      mon_en = 1'b1;
      start_frame("fa");
      repeat (300) @(negedge sys_clock);
      FrameStart = 1'b1;
      @(negedge sys_clock);
      FrameStart = 1'b0;
      wait_done("fa");
      end_frame("fa");
      check("fa_mem0", 32'(mem[0]), 32'h55);
      check("fa_mem1", 32'(mem[1]), 32'h33);
      check("fa_toerr", 32'(TimeoutErr), 0);

      // frame B: reset at pixel (40,5)
      fill_random();
      build_exp();
      start_frame("fb");
      n = 0;
      while (!(PixelX == 7'd40 && PixelY == 7'd5) && n < BUDGET) begin
         @(negedge sys_clock);
         n++;
      end
      check("fb_reach_40_5", 32'(n < BUDGET), 1);
      abort_reset();
      check("fb_no_done", done_cnt, 0);

      // frame C: random values, restart from (0,0)
      fill_random();
      build_exp();
      mon_en = 1'b1;
      start_frame("fc");
      wait_done("fc");
      end_frame("fc");
      check("fc_toerr", 32'(TimeoutErr), 0);

`ifdef AG32GBD_SCAN_TIMEOUT_EN
      // frame D: sampler silent for pixel (9,0)
      fill_random();
      pix_val[0][9] = 2'd0;
      silent_x = 9;
      silent_y = 0;
      build_exp();
      start_frame("fd");
      n = 0;
      while (!(SampleStart && PixelX == 7'd9 && PixelY == 7'd0) && n < BUDGET) begin
         @(negedge sys_clock);
         n++;
      end
      check("fd_reach_9_0", 32'(n < BUDGET), 1);
      t0 = cyc;
      n = 0;
      while (TimeoutErr !== 1'b1 && n < TO + 100) begin
         @(negedge sys_clock);
         n++;
      end
      check("fd_to_latency", cyc - t0, TO + 1);
      silent_x = -1;
      wait_done("fd");
      end_frame("fd");
      check("fd_to_sticky", 32'(TimeoutErr), 1);
      FrameStart = 1'b1;
      @(negedge sys_clock);
      FrameStart = 1'b0;
      check("fd_to_clear", 32'(TimeoutErr), 0);
      abort_reset();
`else
      t0 = 0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
